// File: rtl/wenmiao_responder.sv
// wenmiao_responder: UART command-frame receiver and response-frame transmitter.
// The receive path assembles fixed-length command frames with a gap timeout.
// The transmit path sends SOF_L, SOF_H, a latched payload and a modulo-256 checksum.
// The two paths share only clk and reset_n and otherwise run independently.
module wenmiao_responder #(
    parameter int         CLKS_PER_BIT = 1302,
    parameter int         CMD_LEN      = 20,
    parameter int         RESP_LEN     = 57,
    parameter logic [7:0] SOF_L        = 8'h9F,
    parameter logic [7:0] SOF_H        = 8'hE4,
    parameter int         GAP_TIMEOUT  = 26040
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      rx,
    output logic                      tx,
    input  logic                      resp_start,
    input  logic [(RESP_LEN-3)*8-1:0] resp_payload,
    output logic                      tx_busy,
    output logic                      cmd_frame_done,
    output logic [CMD_LEN*8-1:0]      cmd_frame,
    output logic                      frame_error
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int GW = $clog2(GAP_TIMEOUT + 1);
    localparam int BW = $clog2(CMD_LEN);
    localparam int IW = $clog2(RESP_LEN);
    localparam int PW = (RESP_LEN - 3) * 8;
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(RESP_LEN - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    // ---------------- receive path ----------------
    rx_state_t            rx_state_q, rx_state_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [7:0]           rx_shift_q, rx_shift_d;
    logic [BW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [GW-1:0]        idle_cnt_q, idle_cnt_d;
    logic [CMD_LEN*8-1:0] shadow_q, shadow_d, cmd_frame_q, cmd_frame_d;
    logic                 done_q, done_d, ferr_q, ferr_d;
    logic                 byte_ok, stop_bad, gap_hit;

    // Receiver bit timing: start resampled at half a bit, then one sample per bit period.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_ok    = 1'b0;
        stop_bad   = 1'b0;
        unique case (rx_state_q)
            R_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = R_START;
            end
            R_START: if (rx_cnt_q == HALF_END) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                // A high start sample is a glitch: drop it silently.
                rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
            end
            R_DATA: if (rx_cnt_q == BIT_END) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 1'b1;
                if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
            end
            R_STOP: if (rx_cnt_q == BIT_END) begin
                rx_cnt_d   = '0;
                rx_state_d = R_IDLE;
                byte_ok    = rx_sync_q;
                stop_bad   = !rx_sync_q;
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // Frame assembly, gap timeout and error/done pulse generation.
    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        shadow_d    = shadow_q;
        cmd_frame_d = cmd_frame_q;
        done_d      = 1'b0;
        ferr_d      = 1'b0;
        idle_cnt_d  = idle_cnt_q;
        gap_hit     = (byte_cnt_q != '0) && (idle_cnt_q == GW'(GAP_TIMEOUT));
        if (byte_ok || rx_state_q != R_IDLE) idle_cnt_d = '0;
        else if (idle_cnt_q != GW'(GAP_TIMEOUT)) idle_cnt_d = idle_cnt_q + 1'b1;
        if (byte_ok) begin
            shadow_d[{byte_cnt_q, 3'b000} +: 8] = rx_shift_q;
            if (byte_cnt_q == BW'(CMD_LEN - 1)) begin
                byte_cnt_d  = '0;
                cmd_frame_d = shadow_d;
                done_d      = 1'b1;
            end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
            end
        end else if (stop_bad || gap_hit) begin
            byte_cnt_d = '0;
            ferr_d     = 1'b1;
        end
    end

    // Receive-side registers; synchronizer resets low so a line held low through
    // reset release is not mistaken for a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q   <= 1'b0;
            rx_sync_q   <= 1'b0;
            rx_prev_q   <= 1'b0;
            rx_state_q  <= R_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            byte_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            shadow_q    <= '0;
            cmd_frame_q <= '0;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            byte_cnt_q  <= byte_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            shadow_q    <= shadow_d;
            cmd_frame_q <= cmd_frame_d;
            done_q      <= done_d;
            ferr_q      <= ferr_d;
        end
    end

    // ---------------- transmit path ----------------
    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [IW-1:0] tx_idx_q, tx_idx_d;
    logic [7:0]    tx_shift_q, tx_shift_d, csum_q, csum_d;
    logic [PW-1:0] pay_q, pay_d;
    logic          tx_q, tx_d, busy_q, busy_d;
    logic [IW-1:0] nxt_idx;
    logic [IW+2:0] pay_off;
    logic [7:0]    nxt_byte;

    // Select the byte that follows the one currently on the line.
    always_comb begin
        nxt_idx = tx_idx_q + 1'b1;
        pay_off = {nxt_idx - IW'(2), 3'b000};
        if (nxt_idx == IW'(1))        nxt_byte = SOF_H;
        else if (nxt_idx == LAST_IDX) nxt_byte = csum_q;
        else                          nxt_byte = pay_q[pay_off +: 8];
    end

    // Transmit FSM; tx and tx_busy are computed here and registered with the state.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        csum_d     = csum_q;
        pay_d      = pay_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        unique case (tx_state_q)
            T_IDLE: begin
                tx_cnt_d = '0;
                tx_d     = 1'b1;
                busy_d   = 1'b0;
                if (resp_start) begin
                    pay_d      = resp_payload;
                    tx_state_d = T_START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    tx_idx_d   = '0;
                    tx_shift_d = SOF_L;
                    csum_d     = SOF_L;
                end
            end
            T_START: if (tx_cnt_q == BIT_END) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_state_d = T_DATA;
                tx_d       = tx_shift_q[0];
            end
            T_DATA: if (tx_cnt_q == BIT_END) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 3'd7) begin
                    tx_state_d = T_STOP;
                    tx_d       = 1'b1;
                end else begin
                    tx_bit_d   = tx_bit_q + 1'b1;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_d       = tx_shift_q[1];
                end
            end
            T_STOP: if (tx_cnt_q == BIT_END) begin
                tx_cnt_d = '0;
                if (tx_idx_q == LAST_IDX) begin
                    tx_state_d = T_IDLE;
                    busy_d     = 1'b0;
                    tx_d       = 1'b1;
                end else begin
                    tx_state_d = T_START;
                    tx_d       = 1'b0;
                    tx_idx_d   = nxt_idx;
                    tx_shift_d = nxt_byte;
                    // The checksum covers every byte before itself.
                    if (nxt_idx != LAST_IDX) csum_d = csum_q + nxt_byte;
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    // Transmit-side registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= T_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            csum_q     <= '0;
            pay_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            csum_q     <= csum_d;
            pay_q      <= pay_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign tx             = tx_q;
    assign tx_busy        = busy_q;
    assign cmd_frame_done = done_q;
    assign cmd_frame      = cmd_frame_q;
    assign frame_error    = ferr_q;
endmodule

// File: doc/wenmiao_responder.md
WENMIAO_RESPONDER -- requirements
Module: wenmiao_responder

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- CLKS_PER_BIT, 1302, clocks per UART bit (50 MHz / 38400 bps).
- CMD_LEN, 20, command frame length in bytes.
- RESP_LEN, 57, response frame length in bytes.
- SOF_L, 8'h9F, response byte 0.
- SOF_H, 8'hE4, response byte 1.
- GAP_TIMEOUT, 26040, idle clocks that abort a partial command frame.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- rx  in  1  UART line from host, idle high.
- tx  out  1  UART line to host, idle high.
- resp_start  in  1  one-cycle request to send a response frame.
- resp_payload  in  432  response bytes 2..55; byte k at [8(k-2)+7 : 8(k-2)].
- tx_busy  out  1  response frame in progress.
- cmd_frame_done  out  1  one-cycle pulse when a complete command frame is received.
- cmd_frame  out  160  last complete command; byte k at [8k+7:8k].
- frame_error  out  1  one-cycle pulse on a bad stop bit or a gap timeout.

Function
REQ-003 UART format SHALL be 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), with no parity.
REQ-004 rx SHALL pass through a two-flop synchronizer before any use.
REQ-005 Receiver start detection:
- A falling edge on the synchronized rx in receiver idle starts a byte.
- The start bit is resampled at CLKS_PER_BIT/2.
- If the resampled start bit is high, the byte is abandoned silently and the receiver returns to idle.
REQ-006 Each data bit and the stop bit SHALL be sampled CLKS_PER_BIT clocks after the previous sample.
REQ-007 Stop-bit handling:
- A stop bit sampled low discards the byte, pulses frame_error, and clears the command byte count to 0.
- A stop bit sampled high delivers the byte to frame assembly in the same cycle.
REQ-008 Command frame assembly:
- Delivered bytes are written into a shadow register at index byte_cnt (0..CMD_LEN-1), then byte_cnt increments.
- The command frame carries no header or checksum.
REQ-009 When the byte at index CMD_LEN-1 is delivered:
- The shadow register, including that byte, is copied to cmd_frame on the next cycle.
- cmd_frame_done pulses high for exactly that one cycle.
- byte_cnt returns to 0.
REQ-010 cmd_frame SHALL change only on the copy in REQ-009.
REQ-011 Gap timeout:
- An idle counter clears on every delivered byte and while the receiver is mid-byte, and counts otherwise.
- If byte_cnt > 0 and the idle counter reaches GAP_TIMEOUT, byte_cnt clears to 0, frame_error pulses for one cycle, and cmd_frame is unchanged.
- With byte_cnt = 0 the idle counter saturates and causes no error.
REQ-012 Response acceptance:
- resp_start with tx_busy low latches resp_payload into a frame buffer and raises tx_busy on the next cycle.
- resp_start with tx_busy high is ignored; it is neither queued nor allowed to alter the buffer.
REQ-013 The transmitter state machine SHALL have states IDLE, START, DATA, STOP.
- IDLE to START on acceptance; tx is driven 0 for CLKS_PER_BIT clocks.
- START to DATA; each of 8 bits is held for CLKS_PER_BIT clocks.
- DATA to STOP; tx is driven 1 for CLKS_PER_BIT clocks.
- At the end of STOP: if bytes remain, go to START for the next byte with no extra gap; otherwise go to IDLE.
REQ-014 Transmit byte order SHALL be index 0..56:
- Byte 0 = SOF_L.
- Byte 1 = SOF_H.
- Bytes 2..55 from the latched payload.
- Byte 56 = 8-bit modulo-256 sum of bytes 0..55, accumulated as bytes are loaded.
REQ-015 tx_busy SHALL fall in the cycle the FSM enters IDLE after the stop bit of byte 56; resp_start may be accepted in that same cycle.
REQ-016 tx SHALL be 1 whenever the transmitter is in IDLE.
REQ-017 Receive and transmit paths SHALL operate fully independently and concurrently.

Reset
REQ-018 Asserting reset_n low at any time, including mid-byte or mid-frame, SHALL asynchronously force:
- tx = 1, tx_busy = 0, cmd_frame_done = 0, frame_error = 0, cmd_frame = 0.
- Both FSMs to idle, byte_cnt = 0, all counters and the checksum to 0.
REQ-019 After reset_n is deasserted, the first command byte SHALL be recognized only from a fresh falling edge on rx.

Verification
REQ-020 Send 20 bytes 0x00..0x13 on rx, back to back -> one cmd_frame_done pulse, cmd_frame[7:0] = 8'h00, cmd_frame[159:152] = 8'h13, no frame_error.
REQ-021 Pulse resp_start with resp_payload all 8'h01 -> tx carries 57 bytes: 9F E4, then 54 × 01, then checksum 8'hB9; tx_busy is high for 57 × 10 × 1302 clocks.
REQ-022 Send 7 bytes, then idle for 26040 clocks -> frame_error pulse; a following full 20-byte frame is captured correctly starting at byte 0.
REQ-023 Send a byte with its stop bit forced low -> frame_error pulse, no cmd_frame_done, and byte_cnt = 0.
REQ-024 Pulse resp_start again at byte 10 of a response -> the transmitted frame is unchanged and exactly one frame is sent.
REQ-025 Assert reset_n low during byte 30 of a response while a command is half received -> tx = 1 and tx_busy = 0 immediately; after release, a new command and a new response both complete correctly.
